ring_decoder: RTL and testbench
===============================

Name: ring_decoder

Overview:
- Receive-side companion to the team's one-hot Ring_Counter.
- Samples a DATA_WID-bit ring pattern and checks that exactly one bit is hot.
- Checks that each pattern is the left rotation of the previous one, locks onto a valid sequence, and reports the hot-bit index as binary.
- Counts sequence and one-hot violations. Sits on the consuming end of any ring-counter-driven select/strobe bus.

Parameters:
- DATA_WID, 4, ring width (≥2).
- LOCK_CNT, 2, consecutive correct rotations required to declare lock (≥1).
- ERR_WID, 8, width of saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- ring_in  input  DATA_WID  ring pattern under test.
- ring_vld  input  1  ring_in is sampled on this cycle.
- idx_out  output  $clog2(DATA_WID)  binary position of the hot bit of the last valid one-hot sample.
- idx_vld  output  1  one-cycle pulse: idx_out updated.
- locked  output  1  decoder is in LOCK.
- onehot_err  output  1  one-cycle pulse: sampled ring_in was not one-hot.
- seq_err  output  1  one-cycle pulse: one-hot sample ≠ expected rotation while in ACQ or LOCK.
- err_count  output  ERR_WID  saturating count of onehot_err + seq_err events.

Behaviour:
- Reset (rst=1 at posedge):
  - state=HUNT; prev=0; match=0; idx_out=0; idx_vld=0; locked=0; onehot_err=0; seq_err=0; err_count=0.
  - rst has priority over ring_vld.
  - Reset mid-lock drops locked on the next edge.
- Rotation rule: expected = {prev[DATA_WID-2:0], prev[DATA_WID-1]}. Example: 1000 wraps to 0001.
- One-hot test: popcount(ring_in)==1. All-zero and multi-hot both fail.
- Registered outputs. Every response appears one cycle after the sampling edge (latency 1).
- Cycles with ring_vld=0:
  - No state change.
  - Pulses deassert.
  - idx_out, locked and err_count hold.
- Per sample with ring_vld=1:
  - If one-hot: idx_out=index of hot bit; idx_vld=1; prev=ring_in.
  - If not one-hot: onehot_err=1; idx_out holds; prev holds.
- States:
  - HUNT:
    - one-hot → ACQ, match=0.
    - not one-hot → stay HUNT. onehot_err pulses. err_count unchanged in HUNT.
  - ACQ:
    - one-hot and ==expected → match+1; if match+1==LOCK_CNT → LOCK, locked=1 on the same update.
    - one-hot but ≠expected → seq_err=1, err_count+1, stay ACQ, match=0 (re-seeded from this sample).
    - not one-hot → onehot_err=1, err_count+1, → HUNT.
  - LOCK:
    - ==expected → stay.
    - one-hot ≠expected → seq_err=1, err_count+1, → ACQ, match=0, locked=0.
    - not one-hot → onehot_err=1, err_count+1, → HUNT, locked=0.
- onehot_err and seq_err are never asserted together.
- err_count saturates at 2^ERR_WID−1. It clears only on rst.
- Repeated identical sample (e.g. 0010,0010) is a seq_err, not a hold.

Test Plan (DATA_WID=4, LOCK_CNT=2, ERR_WID=8):
1. Reset, then ring_vld=1 with 0001,0010,0100 on consecutive cycles → idx_out 0,1,2 each one cycle later with idx_vld=1. locked rises on the cycle after 0100 is sampled. err_count=0.
2. Locked sequence continues 1000,0001,0010 → idx_out 3,0,1; locked stays 1 through the 1000→0001 wrap; no error pulses.
3. While locked, inject 0100 where 0001 is expected → seq_err one-cycle pulse; locked=0; err_count=1. Then 1000,0001 → relocks after second correct rotation.
4. While locked, inject 0110, then 0000 → onehot_err pulses on each; idx_out holds last value; state HUNT; err_count increments once (first error, LOCK→HUNT). The second error occurs in HUNT and is not counted.
5. Gap test: locked on 0010, then ring_vld=0 for 5 cycles, then 0100 → no pulses during gap, locked held, 0100 accepted as correct.
6. Saturation and reset: with ERR_WID=2 override, generate 5 seq errors → err_count sticks at 3. Assert rst for one cycle while locked → all outputs 0 on the next edge.

Source files
------------

// File: rtl/ring_decoder.sv
// ring_decoder
//   Receive-side checker for a one-hot ring counter. Each sampled pattern must
//   be one-hot and must be the left rotation of the previous one-hot sample.
//   After LOCK_CNT consecutive correct rotations the decoder reports lock.
//   The hot-bit position is reported in binary, and sequence / one-hot
//   violations are counted in a saturating counter.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high (priority over ring_vld)
//   ring_in    in   [DATA_WID]  ring pattern under test
//   ring_vld   in   ring_in is sampled this cycle
//   idx_out    out  [$clog2(DATA_WID)]  hot-bit index of the last one-hot sample
//   idx_vld    out  one-cycle pulse, idx_out was updated
//   locked     out  decoder is in LOCK
//   onehot_err out  one-cycle pulse, sample was not one-hot
//   seq_err    out  one-cycle pulse, one-hot sample was not the expected rotation
//   err_count  out  [ERR_WID]  saturating count of counted error events
module ring_decoder #(
    parameter int DATA_WID = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_WID  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WID-1:0]         ring_in,
    input  logic                        ring_vld,
    output logic [$clog2(DATA_WID)-1:0] idx_out,
    output logic                        idx_vld,
    output logic                        locked,
    output logic                        onehot_err,
    output logic                        seq_err,
    output logic [ERR_WID-1:0]          err_count
);

    localparam int IDX_W   = $clog2(DATA_WID);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_WID-1:0] prev_q, prev_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                idx_vld_q, idx_vld_d;
    logic                oh_err_q, oh_err_d;
    logic                seq_err_q, seq_err_d;
    logic [ERR_WID-1:0]  err_q, err_d;

    logic                is_onehot;
    logic                is_expected;
    logic [IDX_W-1:0]    hot_idx;
    logic [MATCH_W-1:0]  match_inc;
    logic                bump;

    function automatic logic [DATA_WID-1:0] rotl(input logic [DATA_WID-1:0] v);
        return {v[DATA_WID-2:0], v[DATA_WID-1]};
    endfunction

    function automatic logic [IDX_W-1:0] hot_pos(input logic [DATA_WID-1:0] v);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = 0; i < DATA_WID; i++) begin
            if (v[i]) pos = IDX_W'(i);
        end
        return pos;
    endfunction

    assign is_onehot   = ($countones(ring_in) == 1);
    assign is_expected = (ring_in == rotl(prev_q));
    assign hot_idx     = hot_pos(ring_in);
    assign match_inc   = match_q + MATCH_W'(1);

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        match_d   = match_q;
        idx_d     = idx_q;
        idx_vld_d = 1'b0;
        oh_err_d  = 1'b0;
        seq_err_d = 1'b0;
        bump      = 1'b0;

        if (ring_vld) begin
            // Any one-hot sample updates the index and becomes the new
            // reference, including a mismatching one (ACQ re-seeds from it).
            if (is_onehot) begin
                idx_d     = hot_idx;
                idx_vld_d = 1'b1;
                prev_d    = ring_in;
            end

            unique case (state_q)
                HUNT: begin
                    // Errors while hunting are flagged but not counted.
                    if (is_onehot) begin
                        state_d = ACQ;
                        match_d = '0;
                    end else begin
                        oh_err_d = 1'b1;
                    end
                end
                ACQ: begin
                    if (!is_onehot) begin
                        oh_err_d = 1'b1;
                        bump     = 1'b1;
                        state_d  = HUNT;
                    end else if (is_expected) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_W'(LOCK_CNT)) state_d = LOCK;
                    end else begin
                        seq_err_d = 1'b1;
                        bump      = 1'b1;
                        match_d   = '0;
                    end
                end
                LOCK: begin
                    if (!is_onehot) begin
                        oh_err_d = 1'b1;
                        bump     = 1'b1;
                        state_d  = HUNT;
                    end else if (!is_expected) begin
                        seq_err_d = 1'b1;
                        bump      = 1'b1;
                        match_d   = '0;
                        state_d   = ACQ;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        err_d = (bump && (err_q != '1)) ? err_q + ERR_WID'(1) : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            prev_q    <= '0;
            match_q   <= '0;
            idx_q     <= '0;
            idx_vld_q <= 1'b0;
            oh_err_q  <= 1'b0;
            seq_err_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            match_q   <= match_d;
            idx_q     <= idx_d;
            idx_vld_q <= idx_vld_d;
            oh_err_q  <= oh_err_d;
            seq_err_q <= seq_err_d;
            err_q     <= err_d;
        end
    end

    assign idx_out    = idx_q;
    assign idx_vld    = idx_vld_q;
    assign locked     = (state_q == LOCK);
    assign onehot_err = oh_err_q;
    assign seq_err    = seq_err_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: a directed vector table covering the documented
// scenarios, followed by randomized stimulus against a behavioural model.
// Two instances share the stimulus: ERR_WID=8 (a) and ERR_WID=2 (b).
module tb_ring_decoder;

    localparam int W  = 4;
    localparam int LK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ring_vld;
    logic [3:0] ring_in;

    logic [1:0] idx_a, idx_b;
    logic       iv_a, iv_b, lk_a, lk_b, oh_a, oh_b, sq_a, sq_b;
    logic [7:0] ec_a;
    logic [1:0] ec_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ring_decoder #(.DATA_WID(W), .LOCK_CNT(LK), .ERR_WID(8)) dut_a (
        .clk(clk), .rst(rst), .ring_in(ring_in), .ring_vld(ring_vld),
        .idx_out(idx_a), .idx_vld(iv_a), .locked(lk_a),
        .onehot_err(oh_a), .seq_err(sq_a), .err_count(ec_a)
    );

    ring_decoder #(.DATA_WID(W), .LOCK_CNT(LK), .ERR_WID(2)) dut_b (
        .clk(clk), .rst(rst), .ring_in(ring_in), .ring_vld(ring_vld),
        .idx_out(idx_b), .idx_vld(iv_b), .locked(lk_b),
        .onehot_err(oh_b), .seq_err(sq_b), .err_count(ec_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ec is the unbounded error-event count; each instance saturates it itself.
    task automatic check_all(input string tag, input int e_idx, input int e_iv,
                             input int e_lk, input int e_oh, input int e_sq,
                             input int e_ec);
        chk({tag, " a.idx_out"},    int'(idx_a), e_idx);
        chk({tag, " a.idx_vld"},    int'(iv_a),  e_iv);
        chk({tag, " a.locked"},     int'(lk_a),  e_lk);
        chk({tag, " a.onehot_err"}, int'(oh_a),  e_oh);
        chk({tag, " a.seq_err"},    int'(sq_a),  e_sq);
        chk({tag, " a.err_count"},  int'(ec_a),  (e_ec > 255) ? 255 : e_ec);
        chk({tag, " b.idx_out"},    int'(idx_b), e_idx);
        chk({tag, " b.idx_vld"},    int'(iv_b),  e_iv);
        chk({tag, " b.locked"},     int'(lk_b),  e_lk);
        chk({tag, " b.onehot_err"}, int'(oh_b),  e_oh);
        chk({tag, " b.seq_err"},    int'(sq_b),  e_sq);
        chk({tag, " b.err_count"},  int'(ec_b),  (e_ec > 3) ? 3 : e_ec);
    endtask

    task automatic apply(input logic r, input logic v, input logic [3:0] ring);
        @(negedge clk);
        rst      = r;
        ring_vld = v;
        ring_in  = ring;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] ring;
        int         idx, iv, lk, oh, sq, ec;
    } vec_t;

    vec_t tbl[$];

    // Behavioural reference: mode 0=hunting, 1=acquiring, 2=locked.
    int m_mode, m_prev, m_run, m_idx, m_iv, m_oh, m_sq, m_ec;

    task automatic model_step(input logic r, input logic v, input int ring);
        int exp_ring;
        int ones;
        bit oh;
        m_iv = 0; m_oh = 0; m_sq = 0;
        if (r) begin
            m_mode = 0; m_prev = 0; m_run = 0; m_idx = 0; m_ec = 0;
            return;
        end
        if (!v) return;
        ones = 0;
        for (int i = 0; i < W; i++) if (ring & (1 << i)) ones++;
        oh = (ones == 1);
        exp_ring = ((m_prev * 2) % (1 << W)) + (m_prev / (1 << (W - 1)));
        if (oh) begin
            for (int i = 0; i < W; i++) if (ring == (1 << i)) m_idx = i;
            m_iv = 1;
        end
        if (m_mode == 0) begin
            if (oh) begin m_mode = 1; m_run = 0; end
            else m_oh = 1;
        end else if (!oh) begin
            m_oh = 1; m_ec++; m_mode = 0;
        end else if (ring == exp_ring) begin
            if (m_mode == 1) begin
                m_run++;
                if (m_run == LK) m_mode = 2;
            end
        end else begin
            m_sq = 1; m_ec++; m_run = 0; m_mode = 1;
        end
        if (oh) m_prev = ring;
    endtask

    initial begin
        logic [3:0] rg;
        logic       rr, vv;
        int         sel;

        rst = 1'b1; ring_vld = 1'b0; ring_in = '0;

        //           r     v     ring     idx iv lk oh sq ec
        // reset, acquire and lock
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 4'b0001, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 4'b0010, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 4'b0100, 2, 1, 1, 0, 0, 0});
        // locked run through the wrap
        tbl.push_back('{1'b0, 1'b1, 4'b1000, 3, 1, 1, 0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 4'b0001, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 4'b0010, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 4'b0100, 2, 1, 1, 0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 4'b1000, 3, 1, 1, 0, 0, 0});
        // 0100 where 0001 expected, then relock
        tbl.push_back('{1'b0, 1'b1, 4'b0100, 2, 1, 0, 0, 1, 1});
        tbl.push_back('{1'b0, 1'b1, 4'b1000, 3, 1, 0, 0, 0, 1});
        tbl.push_back('{1'b0, 1'b1, 4'b0001, 0, 1, 1, 0, 0, 1});
        // multi-hot then all-zero: only the first is counted
        tbl.push_back('{1'b0, 1'b1, 4'b0110, 0, 0, 0, 1, 0, 2});
        tbl.push_back('{1'b0, 1'b1, 4'b0000, 0, 0, 0, 1, 0, 2});
        // relock, then a 5-cycle gap with junk on ring_in
        tbl.push_back('{1'b0, 1'b1, 4'b0001, 0, 1, 0, 0, 0, 2});
        tbl.push_back('{1'b0, 1'b1, 4'b0010, 1, 1, 0, 0, 0, 2});
        tbl.push_back('{1'b0, 1'b1, 4'b0100, 2, 1, 1, 0, 0, 2});
        tbl.push_back('{1'b0, 1'b1, 4'b1000, 3, 1, 1, 0, 0, 2});
        tbl.push_back('{1'b0, 1'b1, 4'b0001, 0, 1, 1, 0, 0, 2});
        tbl.push_back('{1'b0, 1'b1, 4'b0010, 1, 1, 1, 0, 0, 2});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{1'b0, 1'b0, 4'b1111, 1, 0, 1, 0, 0, 2});
        tbl.push_back('{1'b0, 1'b1, 4'b0100, 2, 1, 1, 0, 0, 2});
        // repeated identical sample is a sequence error
        tbl.push_back('{1'b0, 1'b1, 4'b0100, 2, 1, 0, 0, 1, 3});
        // rst wins over a valid sample
        tbl.push_back('{1'b1, 1'b1, 4'b1000, 0, 0, 0, 0, 0, 0});
        // five sequence errors (b saturates at 3), lock, then reset while locked
        tbl.push_back('{1'b0, 1'b1, 4'b0001, 0, 1, 0, 0, 0, 0});
        for (int k = 1; k <= 5; k++)
            tbl.push_back('{1'b0, 1'b1, 4'b0001, 0, 1, 0, 0, 1, k});
        tbl.push_back('{1'b0, 1'b1, 4'b0010, 1, 1, 0, 0, 0, 5});
        tbl.push_back('{1'b0, 1'b1, 4'b0100, 2, 1, 1, 0, 0, 5});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 0});

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].r, tbl[k].v, tbl[k].ring);
            check_all($sformatf("tbl[%0d]", k), tbl[k].idx, tbl[k].iv, tbl[k].lk,
                      tbl[k].oh, tbl[k].sq, tbl[k].ec);
        end

        // Random phase: mostly correct rotations, some stray one-hots, some junk.
        model_step(1'b1, 1'b0, 0);
        apply(1'b1, 1'b0, 4'b0000);
        for (int c = 0; c < 3000; c++) begin
            rr  = ($urandom_range(63) == 0);
            vv  = ($urandom_range(3) != 0);
            sel = int'($urandom_range(99));
            if (sel < 60) begin
                if (m_prev == 0) rg = 4'(1 << $urandom_range(3));
                else rg = 4'(((m_prev * 2) % 16) + (m_prev / 8));
            end else if (sel < 80) begin
                rg = 4'(1 << $urandom_range(3));
            end else begin
                rg = 4'($urandom_range(15));
            end
            model_step(rr, vv, int'(rg));
            apply(rr, vv, rg);
            check_all($sformatf("rnd[%0d]", c), m_idx, m_iv, (m_mode == 2) ? 1 : 0,
                      m_oh, m_sq, m_ec);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
